// File: rtl/pixel_buffer.sv
// Per-lane pixel FIFO feeding the contention tree: rasterizer pushes pixels, the tree pulls them
// through a req/ack handshake that pops at most one word per rising edge of req.
module pixel_buffer #(
  parameter int unsigned LENGTH      = 8,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] pix_in,
  input  logic                   wr_en,
  input  logic                   flush,
  input  logic                   req,
  output logic                   ack,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic [LENGTH-1:0]      fill,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LENGTH-1:0]      fill_q, fill_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic                   ack_q, ack_d;
  logic [PIXEL_WIDTH-1:0] pix_out_q, pix_out_d;
  logic [PIXEL_WIDTH-1:0] mem_q [DEPTH];

  logic pop;
  logic wr_accept;
  logic wr_drop;

  // A pop frees the head slot first, so a write on a full FIFO in the same edge is accepted.
  assign pop       = (state_q == StIdle) && req && !empty_q;
  assign wr_accept = wr_en && (!full_q || pop);
  assign wr_drop   = wr_en && full_q && !pop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    ack_d      = 1'b0;
    pix_out_d  = pix_out_q;
    if (flush) begin
      state_d    = StIdle;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PtrW'(1);
        pix_out_d = mem_q[rd_ptr_q];
        ack_d     = 1'b1;
      end
      if (wr_accept && !pop) begin
        fill_d = fill_q + LENGTH'(1);
      end else if (!wr_accept && pop) begin
        fill_d = fill_q - LENGTH'(1);
      end
      if (wr_drop) begin
        overflow_d = 1'b1;
      end
      unique case (state_q)
        StIdle:  if (pop) state_d = StAck;
        StAck:   state_d = req ? StHold : StIdle;
        StHold:  if (!req) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    full_d  = (fill_d == LENGTH'(DEPTH));
    empty_d = (fill_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      pix_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
      pix_out_q  <= pix_out_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept && !flush) begin
      mem_q[wr_ptr_q] <= pix_in;
    end
  end

  assign ack      = ack_q;
  assign pix_out  = pix_out_q;
  assign fill     = fill_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule
